// File: rtl/gpio_in_capture.sv
// gpio_in_capture: Avalon-MM slave that samples external GPIO pins.
// Each pin is synchronised, debounced and edge-captured. Edges are latched
// into a write-1-to-clear register, and a maskable level interrupt is raised.
//
// Bus handshake: there is no waitrequest. avs_read and avs_write are
// single-cycle strobes that are always accepted. avs_readdata is registered
// and holds the addressed register value from the cycle avs_read was high.
// A write in that same cycle takes effect, but the read returns the pre-write
// value.
module gpio_in_capture #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_SEL  = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_next;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] sel_rise;
    logic [WIDTH-1:0] sel_fall;
    logic [31:0]      rd_word;
    logic             unused_writedata;

    // Upper write-data bits beyond the implemented fields are ignored.
    assign unused_writedata = ^avs_writedata;

    // Synchroniser chain: gpio_in crosses into clk_clk through SYNC_STAGES flops.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce next-state: a new level is accepted only after it has been
    // seen for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        deb_next = deb;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (sync[i] == deb[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                deb_next[i] = sync[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Debounced level and per-bit stability counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Edge qualification and write-1-to-clear decode.
    always_comb begin
        rise     = deb_next & ~deb;
        fall     = ~deb_next & deb;
        edge_set = (rise & sel_rise) | (fall & sel_fall);
        edge_clr = '0;
        if (avs_write && (avs_address == ADDR_EDGE)) begin
            edge_clr = avs_writedata[WIDTH-1:0];
        end
    end

    // Edge capture: a new edge wins over a clear of the same bit.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | edge_set;
        end
    end

    // MASK and SEL read/write registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_q   <= '0;
            sel_rise <= '0;
            sel_fall <= '0;
        end else if (avs_write) begin
            if (avs_address == ADDR_MASK) begin
                mask_q <= avs_writedata[WIDTH-1:0];
            end
            if (avs_address == ADDR_SEL) begin
                sel_rise <= avs_writedata[WIDTH-1:0];
                sel_fall <= avs_writedata[16 +: WIDTH];
            end
        end
    end

    // Read multiplexer over the current (pre-write) register values.
    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA: rd_word[WIDTH-1:0] = deb;
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_q;
            ADDR_MASK: rd_word[WIDTH-1:0] = mask_q;
            ADDR_SEL: begin
                rd_word[WIDTH-1:0]  = sel_rise;
                rd_word[16 +: WIDTH] = sel_fall;
            end
            default: rd_word = '0;
        endcase
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_word;
        end
    end

    // Registered level interrupt from any enabled captured edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_q & mask_q);
        end
    end

endmodule
